// File: rtl/pim_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pim_arb_pkg : address field widths and id-width helper for pim_req_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package pim_arb_pkg;

    localparam int BANK_W = 3;
    localparam int ROW_W  = 14;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pim_tag_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pim_tag_fifo : synchronous FIFO of requester ids for in-order response routing
// Rev 1.0
// ---------------------------------------------------------------------------
module pim_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/pim_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pim_req_arbiter : row-hit-first round-robin front end for the DDR3 controller
// Rev 1.0
// ---------------------------------------------------------------------------
module pim_req_arbiter
    import pim_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 512,
    parameter int MAX_OUT    = 4,
    parameter int ROW_LSB    = 13,
    parameter int BANK_LSB   = 10,
    parameter int STARVE_MAX = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          up_req_valid,
    output logic [NUM_REQ-1:0]          up_req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   up_req_addr,
    output logic [NUM_REQ-1:0]          up_resp_valid,
    input  logic [NUM_REQ-1:0]          up_resp_ready,
    output logic [DATA_W-1:0]           up_resp_data,
    output logic                        dn_req_valid,
    input  logic                        dn_req_ready,
    output logic [ADDR_W-1:0]           dn_req_addr,
    input  logic                        dn_resp_valid,
    output logic                        dn_resp_ready,
    input  logic [DATA_W-1:0]           dn_resp_data,
    output logic [31:0]                 grant_count,
    output logic [31:0]                 hit_count,
    output logic                        resp_err
);
    localparam int IDW = id_width(NUM_REQ);
    localparam int CW  = $clog2(MAX_OUT) + 1;
    localparam int SW  = $clog2(STARVE_MAX + 1);

    logic              slot_vld_q, slot_vld_d;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [IDW-1:0]    slot_id_q, slot_id_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              open_valid_q, open_valid_d;
    logic [BANK_W-1:0] open_bank_q, open_bank_d;
    logic [ROW_W-1:0]  open_row_q, open_row_d;
    logic [31:0]       grant_cnt_q, grant_cnt_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic              resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0] hit_vec, cand;
    logic               use_hit, found, grant, grant_en, win_hit, dn_acc;
    logic [IDW-1:0]     win_idx;
    logic [ADDR_W-1:0]  win_addr;
    int                 idx;

    logic               fifo_pop, fifo_full, fifo_empty;
    logic [IDW-1:0]     head_id;
    logic [CW-1:0]      fifo_count;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hit
        wire [ADDR_W-1:0] a = up_req_addr[i*ADDR_W +: ADDR_W];
        assign hit_vec[i] = up_req_valid[i] && open_valid_q
                         && (a[BANK_LSB +: BANK_W] == open_bank_q)
                         && (a[ROW_LSB +: ROW_W] == open_row_q);
    end

    assign dn_acc   = slot_vld_q && dn_req_ready;
    // The slot counts against the outstanding limit since it becomes a tag on accept
    assign grant_en = (!slot_vld_q || dn_acc) && !fifo_full
                   && ((fifo_count + CW'(slot_vld_q)) < CW'(MAX_OUT));
    assign use_hit  = (|hit_vec) && (streak_q < SW'(STARVE_MAX));
    assign cand     = use_hit ? hit_vec : up_req_valid;

    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        win_addr = '0;
        win_hit  = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && cand[idx]) begin
                found    = 1'b1;
                win_idx  = IDW'(idx);
                win_addr = up_req_addr[idx*ADDR_W +: ADDR_W];
                win_hit  = hit_vec[idx];
            end
        end
    end

    assign grant = found && grant_en && !rst;

    always_comb begin
        up_req_ready = '0;
        if (grant) up_req_ready[win_idx] = 1'b1;
    end

    always_comb begin
        slot_vld_d   = slot_vld_q;
        slot_addr_d  = slot_addr_q;
        slot_id_d    = slot_id_q;
        rr_ptr_d     = rr_ptr_q;
        streak_d     = streak_q;
        open_valid_d = open_valid_q;
        open_bank_d  = open_bank_q;
        open_row_d   = open_row_q;
        grant_cnt_d  = grant_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        resp_err_d   = resp_err_q || (dn_resp_valid && fifo_empty);
        if (dn_acc) slot_vld_d = 1'b0;
        if (grant) begin
            slot_vld_d   = 1'b1;
            slot_addr_d  = win_addr;
            slot_id_d    = win_idx;
            rr_ptr_d     = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            open_valid_d = 1'b1;
            open_bank_d  = win_addr[BANK_LSB +: BANK_W];
            open_row_d   = win_addr[ROW_LSB +: ROW_W];
            grant_cnt_d  = grant_cnt_q + 32'd1;
            if (win_hit) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
                streak_d  = (streak_q == SW'(STARVE_MAX)) ? streak_q : streak_q + 1'b1;
            end else begin
                streak_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_q   <= 1'b0;
            slot_addr_q  <= '0;
            slot_id_q    <= '0;
            rr_ptr_q     <= '0;
            streak_q     <= '0;
            open_valid_q <= 1'b0;
            open_bank_q  <= '0;
            open_row_q   <= '0;
            grant_cnt_q  <= '0;
            hit_cnt_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            slot_vld_q   <= slot_vld_d;
            slot_addr_q  <= slot_addr_d;
            slot_id_q    <= slot_id_d;
            rr_ptr_q     <= rr_ptr_d;
            streak_q     <= streak_d;
            open_valid_q <= open_valid_d;
            open_bank_q  <= open_bank_d;
            open_row_q   <= open_row_d;
            grant_cnt_q  <= grant_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
            resp_err_q   <= resp_err_d;
        end
    end

    pim_tag_fifo #(
        .W     (IDW),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (dn_acc),
        .push_data_i (slot_id_q),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_id),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // With no tag outstanding the response is swallowed and flagged
    assign fifo_pop      = dn_resp_valid && !fifo_empty && up_resp_ready[head_id];
    assign dn_resp_ready = fifo_empty ? 1'b1 : up_resp_ready[head_id];

    always_comb begin
        up_resp_valid = '0;
        if (dn_resp_valid && !fifo_empty) up_resp_valid[head_id] = 1'b1;
    end

    assign up_resp_data = dn_resp_data;
    assign dn_req_valid = slot_vld_q;
    assign dn_req_addr  = slot_addr_q;
    assign grant_count  = grant_cnt_q;
    assign hit_count    = hit_cnt_q;
    assign resp_err     = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pim_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pim_req_arbiter : directed self-checking bench for pim_req_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pim_req_arbiter;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     up_req_valid;
    logic [3:0]     up_req_ready;
    logic [127:0]   up_req_addr;
    logic [3:0]     up_resp_valid;
    logic [3:0]     up_resp_ready;
    logic [511:0]   up_resp_data;
    logic           dn_req_valid;
    logic           dn_req_ready;
    logic [31:0]    dn_req_addr;
    logic           dn_resp_valid;
    logic           dn_resp_ready;
    logic [511:0]   dn_resp_data;
    logic [31:0]    grant_count;
    logic [31:0]    hit_count;
    logic           resp_err;

    int n_chk  = 0;
    int n_pass = 0;
    int grant_log[$];
    int route_log[$];
    int last_grant;
    int outstanding;
    int n_acc;
    bit auto_resp;
    int kreq [4];

    always #5 clk = ~clk;

    pim_req_arbiter u_dut (
        .clk           (clk),
        .rst           (rst),
        .up_req_valid  (up_req_valid),
        .up_req_ready  (up_req_ready),
        .up_req_addr   (up_req_addr),
        .up_resp_valid (up_resp_valid),
        .up_resp_ready (up_resp_ready),
        .up_resp_data  (up_resp_data),
        .dn_req_valid  (dn_req_valid),
        .dn_req_ready  (dn_req_ready),
        .dn_req_addr   (dn_req_addr),
        .dn_resp_valid (dn_resp_valid),
        .dn_resp_ready (dn_resp_ready),
        .dn_resp_data  (dn_resp_data),
        .grant_count   (grant_count),
        .hit_count     (hit_count),
        .resp_err      (resp_err)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_addr(input int i, input logic [31:0] a);
        up_req_addr[i*32 +: 32] = a;
    endtask

    // Distinct row per (requester, request number) so no accidental row hits
    function automatic logic [31:0] rr_addr(input int i, input int k);
        return 32'((32 + k * 8 + i) << 13);
    endfunction

    // Samples handshakes just before the edge, then acts as the controller's response side
    task automatic tick();
        bit acc, pop;
        #1;
        acc = dn_req_valid && dn_req_ready;
        pop = dn_resp_valid && dn_resp_ready;
        last_grant = -1;
        for (int i = 0; i < 4; i++) if (up_req_valid[i] && up_req_ready[i]) last_grant = i;
        if (last_grant >= 0) grant_log.push_back(last_grant);
        if (pop) for (int i = 0; i < 4; i++) if (up_resp_valid[i]) route_log.push_back(i);
        @(posedge clk);
        #1;
        if (pop && outstanding > 0) outstanding--;
        if (acc) begin
            outstanding++;
            n_acc++;
        end
        if (auto_resp) dn_resp_valid = (outstanding > 0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        up_req_valid  = '0;
        up_req_addr   = '0;
        up_resp_ready = '0;
        dn_req_ready  = 1'b0;
        dn_resp_valid = 1'b0;
        dn_resp_data  = '0;
        auto_resp     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        grant_log.delete();
        route_log.delete();
        outstanding = 0;
        n_acc       = 0;
        for (int i = 0; i < 4; i++) kreq[i] = 0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        rst = 1'b1;
        up_req_valid = 4'hF;
        #1;
        chk("rst_up_req_ready", up_req_ready, 0);
        rst = 1'b0;
        up_req_valid = '0;
        #1;
        chk("rst_dn_req_valid", dn_req_valid, 0);
        chk("rst_dn_req_addr", dn_req_addr, 0);
        chk("rst_up_resp_valid", up_resp_valid, 0);
        chk("rst_counts", {grant_count, hit_count}, 0);
        chk("rst_resp_err", resp_err, 0);

        // ---------------- single request ----------------
        set_addr(0, 32'h0000_4000);
        up_req_valid = 4'b0001;
        #1;
        chk("single_ready", up_req_ready, 4'b0001);
        tick();
        up_req_valid = '0;
        #1;
        chk("single_dn_valid", dn_req_valid, 1);
        chk("single_dn_addr", dn_req_addr, 32'h0000_4000);
        dn_req_ready = 1'b1;
        tick();
        dn_req_ready = 1'b0;
        dn_resp_valid = 1'b1;
        dn_resp_data  = {64{8'hA5}};
        up_resp_ready = 4'hF;
        #1;
        chk("single_resp_route", up_resp_valid, 4'b0001);
        chk("single_resp_data", up_resp_data, {64{8'hA5}});
        chk("single_dn_resp_ready", dn_resp_ready, 1);
        tick();
        dn_resp_valid = 1'b0;
        #1;
        chk("single_counts", {grant_count, hit_count}, {32'd1, 32'd0});
        chk("single_no_err", resp_err, 0);

        // ---------------- round robin ----------------
        do_reset();
        dn_req_ready  = 1'b1;
        up_resp_ready = 4'hF;
        auto_resp     = 1'b1;
        for (int i = 0; i < 4; i++) set_addr(i, rr_addr(i, 0));
        up_req_valid = 4'hF;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (last_grant >= 0) begin
                kreq[last_grant]++;
                set_addr(last_grant, rr_addr(last_grant, kreq[last_grant]));
            end
        end
        up_req_valid = '0;
        chk("rr_enough_grants", grant_log.size() >= 5, 1);
        chk("rr_enough_resps", route_log.size() >= 5, 1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_grant%0d", k), (k < grant_log.size()) ? grant_log[k] : -1, k % 4);
            chk($sformatf("rr_route%0d", k), (k < route_log.size()) ? route_log[k] : -1, k % 4);
        end
        chk("rr_grant_count", grant_count, grant_log.size());
        chk("rr_hit_count", hit_count, 0);

        // ---------------- row-hit priority and starvation cap ----------------
        do_reset();
        dn_req_ready  = 1'b1;
        up_resp_ready = 4'hF;
        auto_resp     = 1'b1;
        set_addr(0, 32'(100 << 13));
        up_req_valid = 4'b0001;
        tick();
        set_addr(1, 32'(100 << 13) | 32'h40);
        set_addr(2, 32'(200 << 13));
        up_req_valid = 4'b0110;
        for (int c = 0; c < 40 && grant_log.size() < 11; c++) tick();
        up_req_valid = '0;
        chk("starve_ngrants", grant_log.size(), 11);
        for (int k = 1; k <= 10; k++)
            chk($sformatf("starve_grant%0d", k), (k < grant_log.size()) ? grant_log[k] : -1,
                (k <= 8) ? 1 : 2);
        chk("starve_counts", {grant_count, hit_count}, {32'd11, 32'd9});

        // ---------------- outstanding limit ----------------
        do_reset();
        dn_req_ready = 1'b1;
        set_addr(0, rr_addr(0, 0));
        up_req_valid = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (last_grant >= 0) begin
                kreq[0]++;
                set_addr(0, rr_addr(0, kreq[0]));
            end
        end
        #1;
        chk("limit_accepts", n_acc, 4);
        chk("limit_grants", grant_count, 4);
        chk("limit_ready_low", up_req_ready, 0);
        dn_resp_valid = 1'b1;
        dn_resp_data  = {16{32'hC0FFEE01}};
        up_resp_ready = 4'hF;
        #1;
        chk("limit_resp_route", up_resp_valid, 4'b0001);
        tick();
        dn_resp_valid = 1'b0;
        #1;
        chk("limit_ready_after_pop", up_req_ready, 4'b0001);
        up_req_valid = '0;

        // ---------------- response backpressure (3 tags left) ----------------
        up_resp_ready = '0;
        dn_resp_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_dn_ready_low%0d", c), dn_resp_ready, 0);
            chk($sformatf("bp_resp_valid%0d", c), up_resp_valid, 4'b0001);
            tick();
        end
        up_resp_ready = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_drain%0d", c), {up_resp_valid, dn_resp_ready}, {4'b0001, 1'b1});
            tick();
        end

        // ---------------- spurious response ----------------
        #1;
        chk("spur_route_none", up_resp_valid, 0);
        chk("spur_dn_ready", dn_resp_ready, 1);
        chk("spur_err_before", resp_err, 0);
        tick();
        dn_resp_valid = 1'b0;
        #1;
        chk("spur_err_set", resp_err, 1);
        tick();
        tick();
        chk("spur_err_sticky", resp_err, 1);

        // ---------------- asynchronous reset mid-stream ----------------
        set_addr(0, 32'h1234_6000);
        up_req_valid = 4'b0001;
        dn_req_ready = 1'b0;
        tick();
        tick();
        chk("arst_pre_valid", dn_req_valid, 1);
        dn_resp_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dn_req", {dn_req_valid, dn_req_addr}, 0);
        chk("arst_up_ready", up_req_ready, 0);
        chk("arst_up_resp", up_resp_valid, 0);
        chk("arst_counts_err", {grant_count, hit_count, resp_err}, 0);
        rst = 1'b0;
        up_req_valid  = '0;
        dn_resp_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pim_req_arbiter.md
# pim_req_arbiter

Multi-requester front end for the DDR3 DRAM controller. It shares the controller's single request/response port among NUM_REQ requesters, such as host ports and PIM command issuers. Arbitration is row-hit-first round-robin with a starvation cap. An in-order tag FIFO returns each 512-bit response to the requester that issued it. The block sits directly between requester logic and the controller's req/resp handshake.

## Interface
- NUM_REQ, 4, requester count (2..8)
- ADDR_W, 32, request address width
- DATA_W, 512, response data width
- MAX_OUT, 4, max outstanding downstream requests (tag FIFO depth, power of 2)
- ROW_LSB, 13, LSB of row field; row = addr[ROW_LSB +: 14]
- BANK_LSB, 10, LSB of bank field; bank = addr[BANK_LSB +: 3]
- STARVE_MAX, 8, max consecutive row-hit grants before a forced round-robin grant
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- up_req_valid  in  NUM_REQ  per-requester request valid
- up_req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- up_req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- up_resp_valid  out  NUM_REQ  response valid, at most one bit set
- up_resp_ready  in  NUM_REQ  per-requester response accept
- up_resp_data  out  DATA_W  response data, broadcast to all requesters
- dn_req_valid / dn_req_ready / dn_req_addr  out / in / out  1 / 1 / ADDR_W  controller request port
- dn_resp_valid / dn_resp_ready / dn_resp_data  in / out / in  1 / 1 / DATA_W  controller response port
- grant_count  out  32  total upstream grants, wraps
- hit_count  out  32  grants that were row hits, wraps
- resp_err  out  1  sticky: a response arrived with no tag outstanding

## Operation
- Issue slot: one register holding {addr, id}. It is free when empty, or when dn_req_valid && dn_req_ready in the same cycle.
- Grant enable: slot free AND tag FIFO count + (slot occupied ? 1 : 0) < MAX_OUT.
- Hit set: valid requesters whose {bank,row} equals open_{bank,row}, with open_valid = 1.
- Winner: if the hit set is non-empty and streak < STARVE_MAX, the first hit at or after rr_ptr (circular). Otherwise, the first valid requester at or after rr_ptr.
- On grant:
  - up_req_ready[winner] = 1 and the slot loads.
  - rr_ptr <= winner+1 mod NUM_REQ.
  - open_{bank,row} <= winner's address; open_valid <= 1.
  - grant_count++.
  - Hit grant: streak++ and hit_count++. Miss grant: streak <= 0.
- Downstream accept (dn_req_valid && dn_req_ready): push the slot's id into the tag FIFO.
- Response routing: head = FIFO head id.
  - up_resp_valid[head] = dn_resp_valid && !empty.
  - dn_resp_ready = up_resp_ready[head].
  - Pop on handshake.
- Empty FIFO with dn_resp_valid: dn_resp_ready = 1, the data is dropped, resp_err <= 1.
- Simultaneous push and pop: FIFO count is unchanged. This is legal even when the FIFO is full.
- Counters wrap at 2^32 with no saturation.

## Timing
- Reset values:
  - All outputs 0: up_req_ready, up_resp_valid, dn_req_valid, dn_req_addr, counts, resp_err.
  - up_resp_data reflects dn_resp_data and is unconstrained.
  - rr_ptr = 0, streak = 0, open_valid = 0, FIFO empty.
- Request latency: an upstream handshake in cycle N gives dn_req_valid = 1 in cycle N+1. Back-to-back grants are possible at one per cycle while dn_req_ready = 1.
- dn_req_valid / dn_req_addr stay stable until accepted. A grant is never revoked.
- up_req_ready is combinational from up_req_valid and state. A requester must hold valid/addr until ready.
- Response path is combinational, with zero added latency.
- Reset mid-operation: the slot and FIFO clear immediately. Responses already in flight at the shared controller are lost with it; the controller shares reset.

## Structure
- Package pim_arb_pkg: bank/row field widths, and the id width function ($clog2(NUM_REQ), minimum 1).
- Sub-module pim_tag_fifo: sync FIFO, width = id width, depth = MAX_OUT. Provides push/pop/full/empty/count.
- Arbitration, the issue slot and the counters live in pim_req_arbiter.

## Test plan
- Single request: req0 addr 0x0000_4000 → dn_req_valid next cycle with the same addr. A response of 512'hA5.. returns on up_resp_valid[0] only. grant_count = 1, hit_count = 0.
- Round-robin: all 4 requesters valid, distinct rows, dn always ready → grants in order 0,1,2,3,0. Responses route in the same order.
- Row-hit priority and starvation: req1 streams same-row addresses while req2 holds a different row → exactly 8 consecutive req1 grants, then req2 is granted, and streak resets.
- Outstanding limit: dn_resp withheld, MAX_OUT = 4 → 4 downstream accepts, then up_req_ready stays 0 until one response pops.
- Response backpressure: up_resp_ready[head] = 0 for 3 cycles → dn_resp_ready = 0 for those cycles, with no pop or loss.
- Spurious response: dn_resp_valid with the FIFO empty → accepted and dropped, resp_err = 1 until rst. Async rst mid-stream → all outputs 0 in the same cycle.
